// File: rtl/pin_entry_pkg.sv
// Shared constants and state encoding for the PIN-entry buffer and display driver.
package pin_entry_pkg;

  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] MASK  = 4'hE;

  typedef enum logic {ENTRY, DONE} state_t;

endpackage

// File: rtl/pin_entry_display_blink_timer.sv
// Blink phase generator: the phase toggles every TICKS cycles. It can be frozen,
// or restarted to the visible phase (phase_o = 1).
module blink_timer #(
  parameter int TICKS = 12500
) (
  input  logic clk,
  input  logic reset,
  input  logic freeze,
  input  logic restart,
  output logic phase_o
);

  localparam int CW = $clog2(TICKS);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      phase_o  <= 1'b1;
    end else if (restart) begin
      tick_cnt <= '0;
      phase_o  <= 1'b1;
    end else if (!freeze) begin
      if (tick_cnt == CW'(TICKS - 1)) begin
        tick_cnt <= '0;
        phase_o  <= ~phase_o;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pin_entry_display.sv
// PIN-entry buffer and seven-segment nibble driver with a blinking live digit.
// Optional PIN_MASK_EN: committed digits are shown as MASK instead of in clear.
module pin_entry_display
  import pin_entry_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BLINK_TICKS = 12500
) (
  input  logic                        clk_12500hz,
  input  logic                        reset,
  input  logic [3:0]                  value_i,
  input  logic                        enter_i,
  input  logic                        back_i,
  input  logic                        clear_i,
  input  logic                        show_cnt_i,
  input  logic [4*DIGITS-1:0]         cnt_i,
  output logic [4*DIGITS-1:0]         disp_o,
  output logic [4*DIGITS-1:0]         pw_o,
  output logic                        pw_valid_o,
  output logic [$clog2(DIGITS+1)-1:0] count_o
);

  localparam int CW = $clog2(DIGITS + 1);

  state_t       state;
  logic [3:0]   digit_buf [1:DIGITS-1];
  logic         enter_q;
  logic         back_q;
  logic         enter_ev;
  logic         back_ev;
  logic         phase;
  logic [4*DIGITS-1:0] entry_word;
  logic [4*DIGITS-1:0] entry_disp;
  logic [4*DIGITS-1:0] disp_next;

  // Counter view suppresses keypad events but the edge registers keep tracking.
  assign enter_ev = enter_i & ~enter_q & ~show_cnt_i;
  assign back_ev  = back_i  & ~back_q  & ~show_cnt_i;

  assign entry_word[3:0] = value_i;
  assign entry_disp[3:0] = phase ? value_i : BLANK;

  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_slot
    assign entry_word[4*gi +: 4] = digit_buf[gi];
`ifdef PIN_MASK_EN
    assign entry_disp[4*gi +: 4] = (CW'(gi) <= count_o) ? MASK : digit_buf[gi];
`else
    assign entry_disp[4*gi +: 4] = digit_buf[gi];
`endif
  end

  blink_timer #(
    .TICKS(BLINK_TICKS)
  ) u_blink (
    .clk     (clk_12500hz),
    .reset   (reset),
    .freeze  (show_cnt_i),
    .restart (clear_i | (enter_ev & ~back_ev & (state == ENTRY))),
    .phase_o (phase)
  );

  always_ff @(posedge clk_12500hz or posedge reset) begin
    if (reset) begin
      state      <= ENTRY;
      count_o    <= '0;
      pw_o       <= '1;
      pw_valid_o <= 1'b0;
      enter_q    <= 1'b0;
      back_q     <= 1'b0;
      for (int k = 1; k < DIGITS; k++) digit_buf[k] <= BLANK;
    end else begin
      enter_q <= enter_i;
      back_q  <= back_i;
      if (clear_i) begin
        state      <= ENTRY;
        count_o    <= '0;
        pw_valid_o <= 1'b0;
        for (int k = 1; k < DIGITS; k++) digit_buf[k] <= BLANK;
      end else if (state == ENTRY) begin
        if (back_ev) begin
          if (count_o != '0) begin
            for (int k = 1; k < DIGITS - 1; k++) digit_buf[k] <= digit_buf[k+1];
            digit_buf[DIGITS-1] <= BLANK;
            count_o <= count_o - CW'(1);
          end
        end else if (enter_ev) begin
          if (count_o == CW'(DIGITS - 1)) begin
            pw_o       <= entry_word;
            pw_valid_o <= 1'b1;
            count_o    <= CW'(DIGITS);
            state      <= DONE;
          end else begin
            for (int k = DIGITS - 1; k >= 2; k--) digit_buf[k] <= digit_buf[k-1];
            digit_buf[1] <= value_i;
            count_o <= count_o + CW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    disp_next = entry_disp;
    if (show_cnt_i) begin
      disp_next = cnt_i;
    end else if (state == DONE) begin
`ifdef PIN_MASK_EN
      disp_next = {DIGITS{MASK}};
`else
      disp_next = pw_o;
`endif
    end
  end

  always_ff @(posedge clk_12500hz or posedge reset) begin
    if (reset) disp_o <= {DIGITS{BLANK}};
    else       disp_o <= disp_next;
  end

endmodule

// File: tb/tb_pin_entry_display.sv
// Directed self-checking bench: a 4-digit instance for entry/edit/DONE behaviour
// and a 6-digit instance with a short blink period for the blink timing.
module tb_pin_entry_display;

  logic        clk_12500hz = 1'b0;
  logic        reset;

  logic [3:0]  value4, value6;
  logic        enter4, back4, clear4, show4;
  logic        enter6, back6, clear6, show6;
  logic [15:0] cnt4;
  logic [23:0] cnt6;
  logic [15:0] disp4, pw4;
  logic [23:0] disp6, pw6;
  logic        valid4, valid6;
  logic [2:0]  count4, count6;

  int checks = 0;
  int errors = 0;

  always #5 clk_12500hz = ~clk_12500hz;

  pin_entry_display #(.DIGITS(4), .BLINK_TICKS(12500)) dut4 (
    .clk_12500hz (clk_12500hz), .reset (reset),
    .value_i (value4), .enter_i (enter4), .back_i (back4), .clear_i (clear4),
    .show_cnt_i (show4), .cnt_i (cnt4),
    .disp_o (disp4), .pw_o (pw4), .pw_valid_o (valid4), .count_o (count4)
  );

  pin_entry_display #(.DIGITS(6), .BLINK_TICKS(4)) dut6 (
    .clk_12500hz (clk_12500hz), .reset (reset),
    .value_i (value6), .enter_i (enter6), .back_i (back6), .clear_i (clear6),
    .show_cnt_i (show6), .cnt_i (cnt6),
    .disp_o (disp6), .pw_o (pw6), .pw_valid_o (valid6), .count_o (count6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic enter_pulse(input logic [3:0] v);
    @(negedge clk_12500hz);
    value4 = v;
    enter4 = 1'b1;
    @(negedge clk_12500hz);
    enter4 = 1'b0;
  endtask

  task automatic back_pulse();
    @(negedge clk_12500hz);
    back4 = 1'b1;
    @(negedge clk_12500hz);
    back4 = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk_12500hz);
    clear4 = 1'b1;
    @(negedge clk_12500hz);
    clear4 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    value4 = 4'h0; enter4 = 0; back4 = 0; clear4 = 0; show4 = 0; cnt4 = '0;
    value6 = 4'h3; enter6 = 0; back6 = 0; clear6 = 0; show6 = 0; cnt6 = '0;

    #12;
    check("rst_disp", disp4, 32'hFFFF);
    check("rst_pw", pw4, 32'hFFFF);
    check("rst_valid", valid4, 0);
    check("rst_count", count4, 0);

    // Blink: visible for display updates 1..4, hidden 5..8, visible 9..12, ...
    @(negedge clk_12500hz);
    reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk_12500hz);
      check("blink6", disp6, (((n - 1) / 4) % 2 == 0) ? 32'hFFFFF3 : 32'hFFFFFF);
    end

    enter_pulse(4'h1);
    check("count_1", count4, 1);
    enter_pulse(4'h2);
    check("count_2", count4, 2);
    value4 = 4'h7;
    @(negedge clk_12500hz);
`ifdef PIN_MASK_EN
    check("disp_partial", disp4, 32'hFEE7);
`else
    check("disp_partial", disp4, 32'hF127);
`endif

    enter_pulse(4'h3);
    enter_pulse(4'h4);
    check("pw_1234", pw4, 32'h1234);
    check("valid_done", valid4, 1);
    check("count_full", count4, 4);
    @(negedge clk_12500hz);
`ifdef PIN_MASK_EN
    check("disp_done", disp4, 32'hEEEE);
`else
    check("disp_done", disp4, 32'h1234);
`endif
    value4 = 4'h9;
    repeat (5) @(negedge clk_12500hz);
`ifdef PIN_MASK_EN
    check("disp_steady", disp4, 32'hEEEE);
`else
    check("disp_steady", disp4, 32'h1234);
`endif

    enter_pulse(4'h8);
    check("done_enter_ign", count4, 4);
    check("done_pw_held", pw4, 32'h1234);
    back_pulse();
    check("done_back_ign", count4, 4);

    @(negedge clk_12500hz);
    clear4 = 1'b1;
    value4 = 4'h5;
    @(negedge clk_12500hz);
    clear4 = 1'b0;
    check("clr_valid", valid4, 0);
    check("clr_count", count4, 0);
    check("clr_pw_kept", pw4, 32'h1234);
    @(negedge clk_12500hz);
    check("clr_disp", disp4, 32'hFFF5);

    @(negedge clk_12500hz);
    value4 = 4'h6;
    enter4 = 1'b1;
    repeat (100) @(negedge clk_12500hz);
    check("held_enter", count4, 1);
    enter4 = 1'b0;
    @(negedge clk_12500hz);
    check("held_release", count4, 1);

    back_pulse();
    check("back_to_0", count4, 0);
    back_pulse();
    check("back_at_0", count4, 0);

    enter_pulse(4'h5);
    enter_pulse(4'h6);
    back_pulse();
    enter_pulse(4'h7);
    enter_pulse(4'h8);
    enter_pulse(4'h9);
    check("pw_5789", pw4, 32'h5789);
    check("valid_5789", valid4, 1);
    clear_pulse();

    enter_pulse(4'h1);
    @(negedge clk_12500hz);
    enter4 = 1'b1; back4 = 1'b1; value4 = 4'h2;
    @(negedge clk_12500hz);
    enter4 = 1'b0; back4 = 1'b0;
    check("back_beats_ent", count4, 0);

    enter_pulse(4'h2);
    @(negedge clk_12500hz);
    clear4 = 1'b1; enter4 = 1'b1; back4 = 1'b1;
    @(negedge clk_12500hz);
    clear4 = 1'b0; enter4 = 1'b0; back4 = 1'b0;
    check("clear_beats_all", count4, 0);

    enter_pulse(4'h1);
    @(negedge clk_12500hz);
    show4 = 1'b1; cnt4 = 16'h0042; enter4 = 1'b1; value4 = 4'h3;
    @(negedge clk_12500hz);
    enter4 = 1'b0;
    check("cnt_enter_ign", count4, 1);
    @(negedge clk_12500hz);
    check("cnt_disp", disp4, 32'h0042);
    show4 = 1'b0;
    repeat (2) @(negedge clk_12500hz);
    check("no_replay", count4, 1);

    enter_pulse(4'h4);
    #3;
    reset = 1'b1;
    #1;
    check("async_count", count4, 0);
    check("async_disp", disp4, 32'hFFFF);
    @(negedge clk_12500hz);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
